pgm_ioctl_ddram_loader: RTL and testbench
=========================================

// Module: pgm_ioctl_ddram_loader
// PURPOSE
// - Streams HPS ROM downloads (ioctl bus) into DDRAM as 64-bit beats for the PGM core.
// - Packs 8/16-bit ioctl words into beats and routes each ioctl_index to its own DDRAM region.
// - Throttles the HPS through ioctl_wait and reports completion and errors.
// - Sits between hps_io and the DDRAM write port, beside the core's DDRAM read path.
// PARAMETERS
// - IN_W          16         ioctl data width; legal values 8 or 16.
// - DDR_AW        29         DDRAM word-address width, 64-bit units.
// - NUM_REGIONS   4          number of ROM regions; region = ioctl_index[$clog2(NUM_REGIONS)-1:0].
// - REGION_BASE   'h0        packed NUM_REGIONS*DDR_AW vector: base word address per region.
// - REGION_BYTES  '1         packed NUM_REGIONS*32 vector: byte size limit per region.
// - FIFO_DEPTH    16         beat FIFO depth; power of 2, minimum 4.
// - SWAP_BYTES    1          1 = byte-swap 16-bit words (68k big-endian ROM image).
// PORTS
// - clk_sys         in   1       system clock; DDRAM port runs on the same clock.
// - reset_n         in   1       asynchronous active-low reset.
// - ioctl_download  in   1       download active.
// - ioctl_wr        in   1       single-cycle write strobe.
// - ioctl_addr      in   27      byte address within the download.
// - ioctl_dout      in   IN_W    download data.
// - ioctl_index     in   8       download index; selects the region.
// - ioctl_wait      out  1       backpressure to HPS.
// - ddram_addr      out  DDR_AW  DDRAM word address.
// - ddram_din       out  64      write data.
// - ddram_be        out  8       byte enables.
// - ddram_we        out  1       write request.
// - ddram_burstcnt  out  4       always 1.
// - ddram_busy      in   1       Avalon waitrequest.
// - load_busy       out  1       download, packing or drain in progress.
// - load_done       out  1       one-cycle pulse when a download has fully landed in DDRAM.
// - err_range       out  1       sticky: a write exceeded REGION_BYTES or hit an unmapped index.
// - err_ovf         out  1       sticky: a beat was pushed into a full FIFO and dropped.
// BEHAVIOUR
// - Reset values:
//   - All outputs are 0 except ddram_burstcnt = 1.
//   - Beat buffer, FIFO and FSM are cleared asynchronously.
//   - Reset mid-transfer abandons the in-flight beat.
// - Region select:
//   - Region is latched on the rising edge of ioctl_download.
//   - If ioctl_index >= NUM_REGIONS, every write in that download is dropped and sets err_range.
// - Addressing:
//   - Word address = REGION_BASE[r] + ioctl_addr[26:3].
//   - A write with ioctl_addr >= REGION_BYTES[r] is dropped and sets err_range.
// - Lane mapping:
//   - IN_W=16: lane = ioctl_addr[2:1], be |= 2'b11 << 2*lane.
//     - SWAP_BYTES=1: dout[15:8] goes to the lower byte address.
//   - IN_W=8: lane = ioctl_addr[2:0].
// - Beat push rules. The beat buffer holds address, data and be; pushes happen in 1 cycle:
//   - (a) Write to the highest lane (be becomes complete) -> push the completed beat.
//   - (b) Write whose word address differs from the pending beat -> push the old beat; the new data starts a fresh beat in the same cycle.
//   - (c) ioctl_download falls with be != 0 -> push the partial beat.
// - Flow control:
//   - ioctl_wait is registered.
//   - ioctl_wait = 1 while FIFO count >= FIFO_DEPTH-2.
//   - This leaves 2 entries of slack for the 1-cycle HPS response.
//   - A push while the FIFO is full is dropped and sets err_ovf.
// - Writer FSM:
//   - IDLE -> WRITE when the FIFO is not empty. On entry, pop the head and drive addr, din and be.
//   - WRITE holds we=1 with stable address/data/be while ddram_busy=1.
//   - On the first cycle with ddram_busy=0:
//     - Go to WRITE with the next head if the FIFO is not empty, giving back-to-back beats.
//     - Otherwise go to IDLE and drop we.
// - Completion:
//   - load_done pulses once, 1 cycle after all of these hold:
//     - ioctl_download = 0 after a falling edge;
//     - be buffer empty;
//     - FIFO empty;
//     - FSM in IDLE.
//   - load_busy is the OR of these conditions inverted.
// - Overlap: a new download rising before the drain finishes is accepted.
//   - Beats carry their own address.
//   - The earlier load_done is suppressed; only one pulse occurs, at the final drain.
// - Error flags are cleared only by reset or by the rising edge of ioctl_download.
// STRUCTURE
// - Package pgm_loader_pkg:
//   - beat_t {addr[DDR_AW], data[64], be[8]};
//   - wr_state_t {IDLE, WRITE};
//   - lane-width constants.
// - Sub-module pgm_sync_fifo (width = $bits(beat_t), depth FIFO_DEPTH, count output).
// - The rest stays in this file: packer, region decode, writer FSM, status.
// TESTING
// - Region 1 is at base 'h100. Write 16-bit words 0x1122, 0x3344, 0x5566, 0x7788 at addr 0,2,4,6 (SWAP=1).
//   -> Exactly one write: addr 'h100, din 0x8877665544332211 byte order per SWAP, be 8'hFF.
//   -> Then load_done.
// - Single word at addr 2, then download falls.
//   -> One write with be 8'h0C, followed by load_done 1 cycle after we drops.
// - Words at addr 0, then addr 16.
//   -> Two writes: be 8'h03 at base+0 and be 8'h03 at base+2.
// - Hold ddram_busy=1 for 40 cycles while streaming 64 words.
//   -> ioctl_wait rises at FIFO count 14; no err_ovf.
//   -> addr/din stable during busy; all 16 beats land in order.
// - Write at addr >= REGION_BYTES, and a download with index 7 when NUM_REGIONS=4.
//   -> No DDRAM write; err_range=1 until the next download starts.
// - Assert reset_n=0 mid-WRITE.
//   -> we=0, wait=0 and flags cleared immediately.
//   -> After release, a fresh download completes normally.

Source files
------------

// File: rtl/pgm_loader_pkg.sv
// Shared types for the PGM ioctl-to-DDRAM ROM loader.
// Beat bundle, writer states and lane helpers.
package pgm_loader_pkg;

  localparam int BEAT_AW  = 29;
  localparam int BEAT_DW  = 64;
  localparam int BEAT_BEW = 8;
  localparam int LANE_W16 = 16;
  localparam int LANE_W8  = 8;

  typedef struct packed {
    logic [BEAT_AW-1:0]  addr;
    logic [BEAT_DW-1:0]  data;
    logic [BEAT_BEW-1:0] be;
  } beat_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_t;

  function automatic logic [BEAT_DW-1:0] be_mask(
    input logic [BEAT_BEW-1:0] be
  );
    logic [BEAT_DW-1:0] m;
    m = '0;
    for (int i = 0; i < BEAT_BEW; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/pgm_sync_fifo.sv
// Single-clock FIFO with fall-through head and occupancy count.
// Pushes into a full FIFO are ignored; the caller flags them.
module pgm_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rp_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wp_d    = do_push ? wp_q + AW'(1) : wp_q;
    rp_d    = do_pop ? rp_q + AW'(1) : rp_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wp_q] <= din;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pgm_ioctl_ddram_loader.sv
// Packs HPS ioctl download words into 64-bit DDRAM beats,
// routes each index to its region and drains through a FIFO.
module pgm_ioctl_ddram_loader
  import pgm_loader_pkg::*;
#(
  parameter int IN_W        = 16,
  parameter int DDR_AW      = 29,
  parameter int NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*DDR_AW-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*32-1:0]     REGION_BYTES = '1,
  parameter int FIFO_DEPTH  = 16,
  parameter int SWAP_BYTES  = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [IN_W-1:0]   ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic [DDR_AW-1:0] ddram_addr,
  output logic [63:0]       ddram_din,
  output logic [7:0]        ddram_be,
  output logic              ddram_we,
  output logic [3:0]        ddram_burstcnt,
  input  logic              ddram_busy,
  output logic              load_busy,
  output logic              load_done,
  output logic              err_range,
  output logic              err_ovf
);

  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          dl_q;
  logic [RW-1:0] region_q, region_d;
  logic          map_ok_q, map_ok_d;
  beat_t         pend_q, pend_d;
  logic          armed_q, armed_d;
  logic          err_range_q, err_range_d;
  logic          err_ovf_q, err_ovf_d;
  logic          wait_q, wait_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          rise, fall, in_rng, wr_ok, wr_bad;
  logic          fresh, push;
  logic [DDR_AW-1:0] base, word_addr;
  logic [31:0]   limit;
  logic [15:0]   din16, word;
  logic [2:0]    boff;
  logic [63:0]   wdata;
  logic [7:0]    wbe;
  beat_t         seed, merged, push_beat;

  logic          fifo_full, fifo_empty, pop;
  logic [CW-1:0] fifo_count;
  beat_t         head;

  wr_state_t     state_q;
  beat_t         out_q;
  logic          we_q;

  always_comb begin
    rise     = ioctl_download && !dl_q;
    fall     = !ioctl_download && dl_q;
    region_d = rise ? ioctl_index[RW-1:0] : region_q;
    map_ok_d = rise ? (32'(ioctl_index) < NUM_REGIONS) : map_ok_q;

    base      = REGION_BASE[int'(region_d)*DDR_AW +: DDR_AW];
    limit     = REGION_BYTES[int'(region_d)*32 +: 32];
    in_rng    = ({5'd0, ioctl_addr} < limit);
    wr_ok     = ioctl_wr && ioctl_download && map_ok_d && in_rng;
    wr_bad    = ioctl_wr && ioctl_download && !(map_ok_d && in_rng);
    word_addr = base + DDR_AW'(ioctl_addr[26:3]);

    // 68k images are big-endian: the high byte lands at the lower address
    din16 = 16'(ioctl_dout);
    word  = (IN_W == LANE_W16 && SWAP_BYTES != 0) ?
            {din16[7:0], din16[15:8]} : din16;
    boff  = (IN_W == LANE_W16) ?
            {ioctl_addr[2:1], 1'b0} : ioctl_addr[2:0];
    wdata = 64'(word) << {boff, 3'b000};
    wbe   = ((IN_W == LANE_W16) ? 8'h03 : 8'h01) << boff;

    fresh = (pend_q.be == 8'h00) ||
            (pend_q.addr != BEAT_AW'(word_addr));
    seed  = fresh ? '0 : pend_q;
    merged.addr = BEAT_AW'(word_addr);
    merged.data = (seed.data & ~be_mask(wbe)) | wdata;
    merged.be   = seed.be | wbe;

    pend_d    = pend_q;
    push      = 1'b0;
    push_beat = pend_q;
    if (wr_ok) begin
      if (fresh && pend_q.be != 8'h00) push = 1'b1;
      pend_d = merged;
      if (merged.be == 8'hFF && !push) begin
        push      = 1'b1;
        push_beat = merged;
        pend_d    = '0;
      end
    end else if (fall && pend_q.be != 8'h00) begin
      push   = 1'b1;
      pend_d = '0;
    end

    err_range_d = rise ? 1'b0 : err_range_q;
    err_ovf_d   = rise ? 1'b0 : err_ovf_q;
    if (wr_bad) err_range_d = 1'b1;
    if (push && fifo_full) err_ovf_d = 1'b1;

    done_d = armed_q && !ioctl_download &&
             pend_q.be == 8'h00 && fifo_empty &&
             state_q == IDLE;
    armed_d = armed_q;
    if (rise) armed_d = 1'b0;
    else if (fall) armed_d = 1'b1;
    else if (done_d) armed_d = 1'b0;

    busy_d = ioctl_download || pend_q.be != 8'h00 ||
             !fifo_empty || state_q != IDLE;
    wait_d = (fifo_count >= CW'(FIFO_DEPTH - 2));
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q        <= 1'b0;
      region_q    <= '0;
      map_ok_q    <= 1'b0;
      pend_q      <= '0;
      armed_q     <= 1'b0;
      err_range_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      wait_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      dl_q        <= ioctl_download;
      region_q    <= region_d;
      map_ok_q    <= map_ok_d;
      pend_q      <= pend_d;
      armed_q     <= armed_d;
      err_range_q <= err_range_d;
      err_ovf_q   <= err_ovf_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  pgm_sync_fifo #(
    .W     ($bits(beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .push  (push),
    .din   (push_beat),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop = !fifo_empty && (state_q == IDLE || !ddram_busy);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            out_q   <= head;
            we_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (!ddram_busy) begin
            if (!fifo_empty) begin
              out_q <= head;
            end else begin
              we_q    <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ddram_addr     = DDR_AW'(out_q.addr);
  assign ddram_din      = out_q.data;
  assign ddram_be       = out_q.be;
  assign ddram_we       = we_q;
  assign ddram_burstcnt = 4'd1;
  assign ioctl_wait     = wait_q;
  assign load_busy      = busy_q;
  assign load_done      = done_q;
  assign err_range      = err_range_q;
  assign err_ovf        = err_ovf_q;

endmodule

// File: tb/tb_pgm_ioctl_ddram_loader.sv
// Bench for the ioctl DDRAM loader: lane vectors, stream under
// backpressure, range errors and mid-write reset.
module tb_pgm_ioctl_ddram_loader;
  import pgm_loader_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wait;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_we;
  logic [3:0]  ddram_burstcnt;
  logic        ddram_busy = 1'b0;
  logic        load_busy, load_done, err_range, err_ovf;

  pgm_ioctl_ddram_loader #(
    .IN_W         (16),
    .DDR_AW       (29),
    .NUM_REGIONS  (4),
    .REGION_BASE  ({29'h300, 29'h200, 29'h100, 29'h0}),
    .REGION_BYTES ({32'h1000, 32'd32, 32'h1000, 32'h1000}),
    .FIFO_DEPTH   (16),
    .SWAP_BYTES   (1)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .ddram_addr     (ddram_addr),
    .ddram_din      (ddram_din),
    .ddram_be       (ddram_be),
    .ddram_we       (ddram_we),
    .ddram_burstcnt (ddram_burstcnt),
    .ddram_busy     (ddram_busy),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .err_range      (err_range),
    .err_ovf        (err_ovf)
  );

  typedef struct {
    logic [7:0]  idx;
    logic [26:0] a;
    logic [15:0] d;
    logic [28:0] ea;
    logic [63:0] ed;
    logic [7:0]  eb;
  } vec_t;

  vec_t   tv [6];
  beat_t  sb [$];
  int     n_cmp = 0, n_bad = 0;
  int     cyc = 0, n_beats = 0, done_cnt = 0;
  int     last_acc = 0, done_cyc = 0;
  bit     hold_v = 1'b0;
  logic [100:0] h_bus = '0;

  initial forever #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk_sys);
    cyc++;
    if (hold_v && ddram_we) begin
      n_cmp++;
      if ({ddram_addr, ddram_din, ddram_be} !== h_bus) begin
        n_bad++;
        $display("FAIL hold_stable: got %h want %h",
                 {ddram_addr, ddram_din, ddram_be}, h_bus);
      end
    end
    hold_v = ddram_we && ddram_busy;
    h_bus  = {ddram_addr, ddram_din, ddram_be};
    if (ddram_we && !ddram_busy) begin
      beat_t e;
      n_beats++;
      last_acc = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %h %h %h want none",
                 ddram_addr, ddram_din, ddram_be);
      end else begin
        e = sb.pop_front();
        chk("beat_addr", 64'(ddram_addr), 64'(e.addr));
        chk("beat_din", ddram_din, e.data);
        chk("beat_be", 64'(ddram_be), 64'(e.be));
      end
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [26:0] a, input logic [15:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic expect_beat(input logic [28:0] a,
                             input logic [63:0] d,
                             input logic [7:0] b);
    beat_t e;
    e.addr = a;
    e.data = d;
    e.be   = b;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    int d0, k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < 400) begin
      tick();
      k++;
    end
    repeat (4) tick();
    chk(nm, 64'(done_cnt - d0), 64'd1);
    chk({nm, "_sb"}, 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [15:0] sword(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b ^ 8'h5A, b};
  endfunction

  function automatic logic [63:0] sbeat(input int k);
    logic [63:0] d;
    logic [15:0] w;
    d = '0;
    for (int j = 0; j < 4; j++) begin
      w = sword(4*k + j);
      d[16*j +: 16] = {w[7:0], w[15:8]};
    end
    return d;
  endfunction

  initial begin
    int b0, w, k;
    bit saw;

    tv[0] = '{8'd1, 27'd2,  16'hABCD, 29'h100,
              64'h0000_0000_CDAB_0000, 8'h0C};
    tv[1] = '{8'd0, 27'd0,  16'h1234, 29'h000,
              64'h0000_0000_0000_3412, 8'h03};
    tv[2] = '{8'd3, 27'd14, 16'hBEEF, 29'h301,
              64'hEFBE_0000_0000_0000, 8'hC0};
    tv[3] = '{8'd2, 27'd20, 16'h0102, 29'h202,
              64'h0000_0201_0000_0000, 8'h30};
    tv[4] = '{8'd2, 27'd30, 16'h0BAD, 29'h203,
              64'hAD0B_0000_0000_0000, 8'hC0};
    tv[5] = '{8'd1, 27'd44, 16'h55AA, 29'h105,
              64'h0000_AA55_0000_0000, 8'h30};

    repeat (3) tick();
    chk("rst_we", 64'(ddram_we), 0);
    chk("rst_wait", 64'(ioctl_wait), 0);
    chk("rst_done", 64'(load_done), 0);
    chk("rst_busy", 64'(load_busy), 0);
    chk("rst_erange", 64'(err_range), 0);
    chk("rst_eovf", 64'(err_ovf), 0);
    chk("rst_burst", 64'(ddram_burstcnt), 1);
    chk("rst_addr", 64'(ddram_addr), 0);
    chk("rst_din", ddram_din, 0);
    chk("rst_be", 64'(ddram_be), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      expect_beat(tv[i].ea, tv[i].ed, tv[i].eb);
      dl_start(tv[i].idx);
      wr(tv[i].a, tv[i].d);
      tick();
      chk("tv_busy", 64'(load_busy), 1);
      dl_end();
      wait_done("tv_done");
      chk("tv_done_lat", 64'(done_cyc - last_acc), 2);
      chk("tv_erange", 64'(err_range), 0);
    end

    b0 = n_beats;
    expect_beat(29'h100, 64'h8877_6655_4433_2211, 8'hFF);
    dl_start(1);
    wr(0, 16'h1122);
    wr(2, 16'h3344);
    wr(4, 16'h5566);
    wr(6, 16'h7788);
    dl_end();
    wait_done("full_done");
    chk("full_count", 64'(n_beats - b0), 1);

    b0 = n_beats;
    expect_beat(29'h100, 64'h0000_0000_0000_B2A1, 8'h03);
    expect_beat(29'h102, 64'h0000_0000_0000_D4C3, 8'h03);
    dl_start(1);
    wr(0, 16'hA1B2);
    wr(16, 16'hC3D4);
    dl_end();
    wait_done("jump_done");
    chk("jump_count", 64'(n_beats - b0), 2);

    b0 = n_beats;
    for (int i = 0; i < 16; i++)
      expect_beat(29'h100 + 29'(i), sbeat(i), 8'hFF);
    ddram_busy = 1'b1;
    dl_start(1);
    w = 0;
    k = 0;
    saw = 1'b0;
    while (w < 64 && k < 3000) begin
      k++;
      if (ioctl_wait) begin
        if (!saw) begin
          saw = 1'b1;
          chk("wait_rise_words", 64'(w), 61);
          repeat (40) tick();
          chk("wait_held", 64'(ioctl_wait), 1);
          chk("stream_no_ovf", 64'(err_ovf), 0);
          ddram_busy = 1'b0;
        end else begin
          tick();
        end
      end else begin
        wr(27'(2*w), sword(w));
        w++;
      end
    end
    chk("stream_words", 64'(w), 64);
    chk("stream_saw_wait", 64'(saw), 1);
    ddram_busy = 1'b0;
    dl_end();
    wait_done("stream_done");
    chk("stream_count", 64'(n_beats - b0), 16);
    chk("stream_ovf", 64'(err_ovf), 0);

    b0 = n_beats;
    dl_start(2);
    wr(40, 16'h1234);
    tick();
    chk("oor_erange", 64'(err_range), 1);
    dl_end();
    wait_done("oor_done");
    chk("oor_sticky", 64'(err_range), 1);
    dl_start(7);
    chk("unmap_clear", 64'(err_range), 0);
    wr(0, 16'h5555);
    chk("unmap_erange", 64'(err_range), 1);
    dl_end();
    wait_done("unmap_done");
    chk("err_no_beats", 64'(n_beats - b0), 0);

    b0 = n_beats;
    ddram_busy = 1'b1;
    dl_start(2);
    wr(0, 16'h0101);
    wr(2, 16'h0202);
    wr(4, 16'h0303);
    wr(6, 16'h0404);
    wr(40, 16'h0505);
    repeat (3) tick();
    chk("pre_rst_we", 64'(ddram_we), 1);
    chk("pre_rst_erange", 64'(err_range), 1);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("mid_rst_we", 64'(ddram_we), 0);
    chk("mid_rst_wait", 64'(ioctl_wait), 0);
    chk("mid_rst_erange", 64'(err_range), 0);
    chk("mid_rst_busy", 64'(load_busy), 0);
    tick();
    ddram_busy = 1'b0;
    reset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_beats", 64'(n_beats - b0), 0);
    expect_beat(29'h100, 64'h4433_2211_DDCC_BBAA, 8'hFF);
    dl_start(1);
    wr(0, 16'hAABB);
    wr(2, 16'hCCDD);
    wr(4, 16'h1122);
    wr(6, 16'h3344);
    dl_end();
    wait_done("post_rst_done");
    chk("post_rst_count", 64'(n_beats - b0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
